// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use countdown, D-cache
// freeze, buffered branch flush and saturating debug counters.
module hazard_stall_ctrl #(
  parameter int LU_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  IFID_rs_i,
  input  logic [4:0]  IFID_rt_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_rt_i,
  input  logic        mem_stall_i,
  input  logic        branch_taken_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IDEX_bubble_o,
  output logic        IFID_flush_o,
  output logic        pipe_freeze_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] miss_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LU   = 2'd1,
    MEM  = 2'd2
  } state_t;

  localparam logic [2:0] LU_INIT = 3'(LU_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [2:0] lu_cnt_reg, lu_cnt_next;
  logic       pending_flush_reg, pending_flush_next;
  logic       mem_seen_reg;

  logic run;
  logic hazard;
  logic freeze;

  // Gating with rst_i forces every output low while reset is held.
  assign run    = start_i & rst_i;
  assign hazard = run & IDEX_MemRead_i & (IDEX_rt_i != 5'd0) &
                  ((IDEX_rt_i == IFID_rs_i) | (IDEX_rt_i == IFID_rt_i));
  assign freeze = run & mem_stall_i;

  always_comb begin
    state_next         = state_reg;
    lu_cnt_next        = lu_cnt_reg;
    pending_flush_next = pending_flush_reg;
    PCWrite_o          = 1'b0;
    IFIDWrite_o        = 1'b0;
    IDEX_bubble_o      = 1'b0;
    IFID_flush_o       = 1'b0;
    pipe_freeze_o      = 1'b0;

    if (freeze) begin
      PCWrite_o     = 1'b1;
      IFIDWrite_o   = 1'b1;
      pipe_freeze_o = 1'b1;
      // An in-flight load-use countdown is paused, not abandoned.
      if (state_reg != LU) begin
        state_next = MEM;
      end
      if (branch_taken_i) begin
        pending_flush_next = 1'b1;
      end
    end else if (run && (state_reg == LU)) begin
      PCWrite_o     = 1'b1;
      IFIDWrite_o   = 1'b1;
      IDEX_bubble_o = 1'b1;
      lu_cnt_next   = lu_cnt_reg - 3'd1;
      if (lu_cnt_reg == 3'd1) begin
        state_next = IDLE;
      end
    end else if (hazard) begin
      PCWrite_o     = 1'b1;
      IFIDWrite_o   = 1'b1;
      IDEX_bubble_o = 1'b1;
      if (LU_CYCLES > 1) begin
        state_next  = LU;
        lu_cnt_next = LU_INIT;
      end else begin
        state_next = IDLE;
      end
    end else if (run) begin
      // MEM exit lands here too: the first unfrozen cycle behaves as IDLE.
      IFID_flush_o       = branch_taken_i | pending_flush_reg;
      pending_flush_next = 1'b0;
      state_next         = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg         <= IDLE;
      lu_cnt_reg        <= 3'd0;
      pending_flush_reg <= 1'b0;
      mem_seen_reg      <= 1'b0;
    end else begin
      state_reg         <= state_next;
      lu_cnt_reg        <= lu_cnt_next;
      pending_flush_reg <= pending_flush_next;
      mem_seen_reg      <= freeze;
    end
  end

  // Counter 0 counts PC-hold cycles, counter 1 counts rising edges of freeze.
  logic [1:0] cnt_inc;
  assign cnt_inc[0] = PCWrite_o;
  assign cnt_inc[1] = freeze & ~mem_seen_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          cnt_reg <= 32'd0;
        end else if (cnt_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end
    end
  endgenerate

  assign stall_cnt_o = g_cnt[0].cnt_reg;
  assign miss_cnt_o  = g_cnt[1].cnt_reg;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage core. It generates the PC hold signal, IF/ID hold and flush, the ID/EX bubble, and the back-end freeze, and it is the driver of the PC register's hold input. Load-use stalls use a parameterised countdown. A data-cache miss freezes the whole pipe. A taken branch that arrives during a freeze is buffered and applied when the freeze ends. Saturating stall and miss counters are exposed for debug.

## Interface
- LU_CYCLES, 1: load-use stall length in cycles, legal range 1..7.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  core run enable; while 0, hazards are ignored.
- IFID_rs_i  in  5  rs field of the instruction in IF/ID.
- IFID_rt_i  in  5  rt field of the instruction in IF/ID.
- IDEX_MemRead_i  in  1  instruction in ID/EX is a load.
- IDEX_rt_i  in  5  destination register of the load in ID/EX.
- mem_stall_i  in  1  data cache busy (miss in service).
- branch_taken_i  in  1  branch resolved taken in ID.
- PCWrite_o  out  1  1 = PC holds its value.
- IFIDWrite_o  out  1  1 = IF/ID holds its value.
- IDEX_bubble_o  out  1  1 = load NOP control into ID/EX.
- IFID_flush_o  out  1  1 = clear IF/ID to NOP.
- pipe_freeze_o  out  1  1 = hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  32  cycles with PCWrite_o=1, saturating.
- miss_cnt_o  out  32  count of freeze episodes, saturating.

## Operation
Definitions:
- hazard = start_i & IDEX_MemRead_i & (IDEX_rt_i != 0) & (IDEX_rt_i == IFID_rs_i | IDEX_rt_i == IFID_rt_i).
- freeze = start_i & mem_stall_i.

All outputs are combinational from the state registers and the current inputs, so a stall takes effect in the same cycle. While rst_i = 0, every output is 0.

States:
- IDLE, LU, MEM. There is also a 3-bit countdown lu_cnt, a pending_flush flag and a mem_seen flag.

Priority, evaluated every cycle:
- freeze, then LU state, then hazard, then branch.

Behaviour by condition:
- **freeze**:
  - PCWrite_o, IFIDWrite_o and pipe_freeze_o are 1; IDEX_bubble_o and IFID_flush_o are 0.
  - State goes to MEM, unless the current state is LU, in which case it stays LU and lu_cnt is paused.
  - branch_taken_i = 1 sets pending_flush.
- **LU state, not frozen**:
  - PCWrite_o, IFIDWrite_o and IDEX_bubble_o are 1.
  - lu_cnt decrements; when lu_cnt == 1 the next state is IDLE.
  - A taken branch cannot occur while an instruction is held; branch_taken_i is ignored.
- **IDLE or MEM, not frozen, hazard**:
  - PCWrite_o, IFIDWrite_o and IDEX_bubble_o are 1.
  - If LU_CYCLES > 1, the next state is LU with lu_cnt = LU_CYCLES-1; otherwise the next state is IDLE.
- **IDLE or MEM, not frozen, no hazard**:
  - IFID_flush_o = branch_taken_i | pending_flush.
  - pending_flush clears; the next state is IDLE.
- **MEM exit**: the first cycle with mem_stall_i = 0 is evaluated as IDLE in that same cycle, including hazard detection and flush.
- **start_i = 0**:
  - All outputs are 0; state, lu_cnt and pending_flush are held; counters do not count.

Counters:
- stall_cnt_o increments on every cycle with PCWrite_o = 1.
- miss_cnt_o increments on each cycle where freeze = 1 and the previous cycle had freeze = 0 (tracked with the registered mem_seen).
- Both counters saturate at 32'hFFFFFFFF.

## Timing
- Stall and flush latency: 0 cycles, because outputs are combinational.
- State, lu_cnt, pending_flush, mem_seen and counters update on the rising edge of clk_i.
- Reset values: state IDLE, lu_cnt 0, pending_flush 0, mem_seen 0, stall_cnt_o 0, miss_cnt_o 0; all outputs 0.
- Reset asserted mid-LU or mid-MEM: the controller returns to IDLE immediately and asynchronously, and any pending flush is lost.
- A load-use stall lasts exactly LU_CYCLES unfrozen cycles, regardless of any freeze cycles interleaved with it.
- A buffered flush is applied in exactly one cycle: the first unfrozen cycle that is not a stall cycle.

## Test plan
- **Reset and idle**: with rst_i = 0 and arbitrary inputs -> all outputs 0 and both counters 0. Release reset with no hazard -> outputs stay 0.
- **Single load-use stall** (LU_CYCLES = 1): IDEX_MemRead_i = 1, IDEX_rt_i = 5, IFID_rs_i = 5 for one cycle -> PCWrite_o, IFIDWrite_o and IDEX_bubble_o are 1 for that one cycle, and stall_cnt_o = 1.
  - Repeat with IDEX_rt_i = 0 -> no stall.
- **Multi-cycle load-use stall** (LU_CYCLES = 3): hazard present for one cycle, then removed -> three consecutive stall cycles, then IDLE, and stall_cnt_o = 3.
- **Freeze with buffered branch**: mem_stall_i = 1 for 4 cycles, with branch_taken_i pulsed in the 2nd cycle -> pipe_freeze_o = 1 for cycles 1-4, IFID_flush_o = 1 in cycle 5 only, miss_cnt_o = 1, stall_cnt_o = 4.
- **Freeze during LU countdown** (LU_CYCLES = 3): mem_stall_i = 1 for 2 cycles after the first stall cycle -> total of 5 PCWrite_o cycles, of which the bubble is 1 only on the 3 unfrozen cycles.
- **Run enable and reset interactions**:
  - With start_i = 0 and a hazard plus mem_stall_i applied -> all outputs 0 and counters unchanged.
  - Assert rst_i low mid-LU -> state IDLE and counters 0 immediately.
